// File: rtl/charram_fill_dma.sv
`default_nettype none
// ============================================================================
// Module   : charram_fill_dma
// Purpose  : Fill engine and port-A arbiter for the character-map RAMs
//            (chram, fgcolram, bgcolram). The CPU programs start, length,
//            fill value and target mask, then the engine writes one byte per
//            clock into the selected RAMs in cycles the CPU leaves free.
// Ports    : clk_24/reset_n            clock, async active-low reset
//            reg_cs/reg_wr/reg_addr/   register window (8 registers)
//            reg_din/reg_dout
//            cpu_ram_cs/cpu_addr/      CPU side of the character RAMs
//            cpu_din/cpu_*_wr
//            ram_addr/ram_din/*_we     shared port A to the three RAMs
//            busy/done                 fill in progress / completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module charram_fill_dma #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk_24,
    input  logic              reset_n,
    input  logic              reg_cs,
    input  logic              reg_wr,
    input  logic [2:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_din,
    output logic [DATA_W-1:0] reg_dout,
    input  logic              cpu_ram_cs,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_chram_wr,
    input  logic              cpu_fgcol_wr,
    input  logic              cpu_bgcol_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              chram_we,
    output logic              fgcol_we,
    output logic              bgcol_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_ptr;
    logic [11:0]       r_len;
    logic [11:0]       r_rem;
    logic [DATA_W-1:0] r_fill;
    logic [2:0]        r_mask;

    logic w_busy;
    logic w_reg_wr;
    logic w_ctrl_wr;
    logic w_abort;
    logic w_start;
    logic w_dma_wr;

    assign w_busy    = (r_state == ST_RUN);
    assign w_reg_wr  = reg_cs & reg_wr;
    assign w_ctrl_wr = w_reg_wr & (reg_addr == 3'd5);
    // Abort only has meaning during a fill; outside RUN the bit is ignored
    // but it still vetoes a start written in the same CTRL write.
    assign w_abort   = w_ctrl_wr & reg_din[6] & w_busy;
    assign w_start   = w_ctrl_wr & reg_din[7] & ~reg_din[6] & ~w_busy;
    // The abort cycle itself carries no DMA write so rem keeps the exact
    // count of bytes never written.
    assign w_dma_wr  = w_busy & ~cpu_ram_cs & ~w_abort;

    assign busy = w_busy;
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------------
    // Register file, pointer and remaining counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            r_start <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_mask  <= '0;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            // Configuration is frozen while a fill runs.
            if (w_reg_wr && !w_busy) begin
                case (reg_addr)
                    3'd0:    r_start[7:0]        <= reg_din[7:0];
                    3'd1:    r_start[ADDR_W-1:8] <= reg_din[ADDR_W-9:0];
                    3'd2:    r_len[7:0]          <= reg_din[7:0];
                    3'd3:    r_len[11:8]         <= reg_din[3:0];
                    3'd4:    r_fill              <= reg_din;
                    3'd5:    r_mask              <= reg_din[2:0];
                    default: ;
                endcase
            end
            if (w_start) begin
                r_ptr <= r_start;
                r_rem <= r_len;
            end else if (w_dma_wr) begin
                r_ptr <= r_ptr + ADDR_W'(1);
                r_rem <= r_rem - 12'd1;
            end
        end
    end

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and port-A arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        ram_addr    = cpu_addr;
        ram_din     = cpu_din;
        chram_we    = 1'b0;
        fgcol_we    = 1'b0;
        bgcol_we    = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (w_start) begin
                    // Nothing to write: complete without ever going busy.
                    if (r_len == 12'd0 || reg_din[2:0] == 3'b000) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_abort || (w_dma_wr && r_rem == 12'd1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (cpu_ram_cs) begin
            chram_we = cpu_chram_wr;
            fgcol_we = cpu_fgcol_wr;
            bgcol_we = cpu_bgcol_wr;
        end else if (w_dma_wr) begin
            ram_addr = r_ptr;
            ram_din  = r_fill;
            chram_we = r_mask[0];
            fgcol_we = r_mask[1];
            bgcol_we = r_mask[2];
        end
    end

    // ------------------------------------------------------------------
    // Register readback (combinational)
    // ------------------------------------------------------------------
    always_comb begin
        reg_dout = '0;
        case (reg_addr)
            3'd0:    reg_dout = DATA_W'(r_start[7:0]);
            3'd1:    reg_dout = DATA_W'(r_start[ADDR_W-1:8]);
            3'd2:    reg_dout = DATA_W'(r_len[7:0]);
            3'd3:    reg_dout = DATA_W'(r_len[11:8]);
            3'd4:    reg_dout = r_fill;
            3'd5:    reg_dout = DATA_W'({w_busy, 4'b0000, r_mask});
            3'd6:    reg_dout = DATA_W'(r_rem[7:0]);
            3'd7:    reg_dout = DATA_W'(r_rem[11:8]);
            default: reg_dout = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/charram_fill_dma.md
# charram_fill_dma

Fill engine and port arbiter for the Casval character-map RAMs (chram, fgcolram, bgcolram). It sits between the tv80s CPU bus and the CPU-side (port A) of the three character RAMs. The CPU programs a start address, length, fill value and target mask through a small register window; the engine then writes the fill value one byte per clock into the selected RAMs. The CPU always wins the shared RAM port, and the engine writes only in cycles the CPU leaves free.

## Interface
Parameters:
- ADDR_W, 11, character RAM address width (2048 bytes per RAM)
- DATA_W, 8, RAM data width

Ports:
- clk_24  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- reg_cs  in  1  register window select (decoded by system)
- reg_wr  in  1  register write strobe; meaningful only with reg_cs
- reg_addr  in  3  register index
- reg_din  in  DATA_W  CPU write data
- reg_dout  out  DATA_W  register read data, combinational from reg_addr
- cpu_ram_cs  in  1  CPU is addressing any character RAM this cycle
- cpu_addr  in  ADDR_W  CPU RAM address
- cpu_din  in  DATA_W  CPU write data for the RAMs
- cpu_chram_wr, cpu_fgcol_wr, cpu_bgcol_wr  in  1 each  CPU write enables
- ram_addr  out  ADDR_W  shared port-A address to all three RAMs
- ram_din  out  DATA_W  shared port-A write data
- chram_we, fgcol_we, bgcol_we  out  1 each  port-A write enables
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse when a fill completes or is aborted

## Operation
Register map:
- 0: START_LO, start[7:0]
- 1: START_HI, start[10:8]; upper bits are ignored
- 2: LEN_LO, len[7:0]
- 3: LEN_HI, len[11:8]; len is 12 bits, valid range 0..2048
- 4: FILL, fill value
- 5: CTRL
  - Write: bit0 chram, bit1 fgcol, bit2 bgcol, bit6 abort, bit7 start.
  - Read: {busy, 4'b0, mask[2:0]}.
- 6: REM_LO, remaining count [7:0], read-only
- 7: REM_HI, {4'b0, remaining[11:8]}, read-only
- Registers 0-4 read back the values written.

State machine:
- IDLE
  - A write to CTRL with bit7=1 latches mask = bit[2:0], loads ptr = start and rem = len.
  - If len==0 or mask==0, go to DONE; otherwise go to RUN.
- RUN
  - In each cycle with cpu_ram_cs=0, assert the masked write enables with ram_addr=ptr and ram_din=fill.
  - Then ptr = ptr+1 (wraps 0x7FF→0x000) and rem = rem-1.
  - If rem reaches 0, go to DONE.
  - In cycles with cpu_ram_cs=1, the CPU passes through unchanged and ptr and rem hold.
- DONE: done=1 for one cycle, then IDLE.

Arbitration mux:
- cpu_ram_cs=1: ram_addr=cpu_addr, ram_din=cpu_din, each we = the matching cpu_*_wr.
- RUN with cpu_ram_cs=0: DMA values as above.
- Otherwise: ram_addr=cpu_addr, ram_din=cpu_din, all we=0.

Register writes and start:
- A write to CTRL with bit6=1 while busy goes to DONE immediately. rem holds the unwritten count.
- Writes to registers 0-4 while busy are ignored.
- A CTRL start while busy is ignored.
- Abort and start set together: abort wins.
- A CTRL write in IDLE without bit7 only updates mask.

Reset:
- Async assertion of reset_n → IDLE.
- All registers, ptr and rem = 0; busy=0, done=0, all DMA write enables 0. Pass-through still follows the CPU inputs.
- A fill interrupted by reset is discarded, with no further writes.

## Timing
- The CTRL start write is sampled at posedge N. busy=1 from N+1, and the first DMA write is presented in cycle N+1 if cpu_ram_cs=0.
- A fill of L bytes with S CPU-stall cycles occupies exactly L+S cycles in RUN.
- done pulses in the cycle after the last write. busy falls in that same cycle: busy=1 exactly while in RUN.
- With len==0 or mask==0: busy stays 0 and done pulses at N+1.
- The mux and write enables are combinational from state and the CPU inputs, so the RAMs capture at the next posedge.
- reg_dout is combinational. REM reflects rem after the previous edge.

## Test plan
- Fill start=0x000, len=0x4B0, fill=0x20, mask=chram with no CPU traffic:
  - busy for 1200 cycles, then done.
  - chram[0..0x4AF]=0x20 and chram[0x4B0] untouched; fgcol/bgcol untouched.
- Wrap: start=0x7FE, len=4, mask=fgcol|bgcol, fill=0xA5:
  - writes at 0x7FE, 0x7FF, 0x000, 0x001 in both RAMs.
  - REM reads 0 afterwards.
- Contention: len=16, and the CPU writes 0x55 to chram 0x100 with cpu_ram_cs high for 3 cycles mid-fill:
  - the CPU write lands, and the fill completes in 19 cycles.
  - no DMA write occurs in any cpu_ram_cs cycle.
- Abort: len=100, CTRL=0x40 written after 10 DMA writes:
  - done next cycle, REM=90, no further writes.
  - a subsequent start works normally.
- Degenerate and ignored writes:
  - len=0 start → done at N+1, busy never set, no writes.
  - a start during busy is ignored, and START_LO writes during busy don't change readback.
- Reset mid-fill: drop reset_n asynchronously after 5 writes:
  - busy, done and all DMA write enables drop to 0 immediately.
  - all registers read 0 after release.
